// File: rtl/shape_tx_pkg.sv
// Shared types for the shape_tx block.
// IShapeType is the message carried on the shapeOut valid/ready channel:
// the array1 elements plus a mask telling which elements were written
// since the last commit.
package shape_tx_pkg;

    localparam int ARRAY1_LEN = 4;
    localparam int ELEM_W     = 39;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic [ARRAY1_LEN-1:0][ELEM_W-1:0] array1;
        logic [ARRAY1_LEN-1:0]             written;
    } IShapeType;

endpackage

// File: rtl/shape_tx_if.sv
// Valid/ready channel carrying one shape message per transfer.
//   valid : producer has a message on data
//   ready : consumer accepts the message this cycle
//   data  : the message (shape_t, IShapeType by default)
// The message type is a parameter so a differently sized shape can reuse
// the same channel.
interface shape_tx_if
    import shape_tx_pkg::*;
#(
    parameter type shape_t = IShapeType
) ();

    logic   valid;
    logic   ready;
    shape_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/shape_tx_fifo.sv
// DEPTH-entry register FIFO of shape messages.
//   push/push_data : write an entry; ignored while full
//   pop            : drop the head entry; ignored while empty
//   head           : head entry, all-zero while empty
//   full/empty     : decoded from the registered occupancy only, so a pop
//                    never makes room for a push in the same cycle
module shape_tx_fifo
    import shape_tx_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type shape_t = IShapeType
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   push,
    input  shape_t push_data,
    input  logic   pop,
    output shape_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    shape_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shape_tx.sv
// Transmit end of the shape channel.
// Upstream writes elements into a staging register, then commits; each
// accepted commit pushes one message into an output FIFO that drives the
// shapeOut valid/ready channel.
//   clk, rstn          : clock, async active-low reset
//   wr_en/wr_idx/wr_data : staging element write (out-of-range idx ignored)
//   commit             : push staged shape (merged with same-cycle write)
//   commit_ready       : FIFO has room; a commit is accepted this cycle
//   shapeOut           : valid/ready message channel (master side)
//   sent_count         : transfers on shapeOut, wraps
//   drop_count         : commits refused while full, saturates
module shape_tx
    import shape_tx_pkg::*;
#(
    parameter int  ARRAY1_LEN = shape_tx_pkg::ARRAY1_LEN,
    parameter int  ELEM_W     = shape_tx_pkg::ELEM_W,
    parameter int  DEPTH      = 2,
    parameter type shape_t    = IShapeType
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [((ARRAY1_LEN > 1) ? $clog2(ARRAY1_LEN) : 1)-1:0] wr_idx,
    input  logic [ELEM_W-1:0]    wr_data,
    input  logic                 commit,
    output logic                 commit_ready,
    shape_tx_if.master           shapeOut,
    output logic [CNT_W-1:0]     sent_count,
    output logic [CNT_W-1:0]     drop_count
);

    shape_t stage_q;
    shape_t merged;
    logic   write_hit;
    logic   commit_ok;
    logic   fifo_full;
    logic   fifo_empty;

    assign write_hit = wr_en && (int'(wr_idx) < ARRAY1_LEN);

    // The message leaving on a commit includes a write made in that cycle.
    always_comb begin
        merged = stage_q;
        if (write_hit) begin
            merged.array1[wr_idx]  = wr_data;
            merged.written[wr_idx] = 1'b1;
        end
    end

    assign commit_ready = !fifo_full;
    assign commit_ok    = commit && commit_ready;

    // A refused commit leaves staging intact (including any same-cycle
    // write) so upstream can simply retry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else if (commit_ok) begin
            stage_q <= '0;
        end else if (write_hit) begin
            stage_q <= merged;
        end
    end

    shape_tx_fifo #(
        .DEPTH   (DEPTH),
        .shape_t (shape_t)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (commit_ok),
        .push_data (merged),
        .pop       (shapeOut.ready),
        .head      (shapeOut.data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign shapeOut.valid = !fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sent_count <= '0;
            drop_count <= '0;
        end else begin
            if (shapeOut.valid && shapeOut.ready) begin
                sent_count <= sent_count + CNT_W'(1);
            end
            if (commit && !commit_ready && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shape_tx.sv
// Bench for shape_tx: default-size instance driven through a scoreboard of
// expected messages, plus a 5-element instance for index range handling.
module tb_shape_tx;
    import shape_tx_pkg::*;

    typedef struct packed {
        logic [4:0][38:0] array1;
        logic [4:0]       written;
    } shape5_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_en, commit, commit_ready;
    logic [1:0]  wr_idx;
    logic [38:0] wr_data;
    logic [15:0] sent_count, drop_count;

    logic        wr_en5, commit5, commit_ready5;
    logic [2:0]  wr_idx5;
    logic [38:0] wr_data5;
    logic [15:0] sent_count5, drop_count5;

    shape_tx_if bus ();
    shape_tx_if #(.shape_t(shape5_t)) bus5 ();

    shape_tx dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .commit       (commit),
        .commit_ready (commit_ready),
        .shapeOut     (bus),
        .sent_count   (sent_count),
        .drop_count   (drop_count)
    );

    shape_tx #(.ARRAY1_LEN(5), .shape_t(shape5_t)) dut5 (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en5),
        .wr_idx       (wr_idx5),
        .wr_data      (wr_data5),
        .commit       (commit5),
        .commit_ready (commit_ready5),
        .shapeOut     (bus5),
        .sent_count   (sent_count5),
        .drop_count   (drop_count5)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_err = 0;
    IShapeType sb[$];
    IShapeType e;
    shape5_t   e5;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Head of the channel must equal the oldest expected message whenever
    // valid is up; it leaves the scoreboard on a sampled valid && ready.
    always @(negedge clk) begin
        if (rstn && bus.valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", bus.valid, 1'b0);
            end else begin
                check_val("head", bus.data, sb[0]);
                if (bus.ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rstn = 1'b0; wr_en = 0; wr_idx = 0; wr_data = 0; commit = 0;
        wr_en5 = 0; wr_idx5 = 0; wr_data5 = 0; commit5 = 0;
        bus.ready = 1'b0; bus5.ready = 1'b0;
        #12;
        check_val("rst_valid", bus.valid, 1'b0);
        check_val("rst_data", bus.data, '0);
        check_val("rst_commit_ready", commit_ready, 1'b1);
        check_val("rst_sent", sent_count, 16'd0);
        check_val("rst_drop", drop_count, 16'd0);
        tick();
        rstn = 1'b1;
        tick();

        // single message
        bus.ready = 1'b1;
        wr_en = 1; wr_idx = 2'd1; wr_data = 39'h00DEADBEEF;
        tick();
        wr_en = 0;
        check_val("t1_idle", bus.valid, 1'b0);
        commit = 1;
        e = '0; e.array1[1] = 39'h00DEADBEEF; e.written[1] = 1'b1;
        sb.push_back(e);
        tick();
        commit = 0;
        check_val("t1_valid", bus.valid, 1'b1);
        tick();
        check_val("t1_sent", sent_count, 16'd1);
        tick();

        // same-cycle write and commit, then an all-zero commit
        wr_en = 1; wr_idx = 2'd3; wr_data = 39'h7F00000001; commit = 1;
        e = '0; e.array1[3] = 39'h7F00000001; e.written[3] = 1'b1;
        sb.push_back(e);
        tick();
        wr_en = 0;
        sb.push_back('0);
        tick();
        commit = 0;
        repeat (3) tick();
        check_val("t2_sent", sent_count, 16'd3);

        // backpressure with DEPTH = 2
        bus.ready = 1'b0;
        wr_en = 1; wr_idx = 2'd0; wr_data = 39'h11; commit = 1;
        e = '0; e.array1[0] = 39'h11; e.written[0] = 1'b1; sb.push_back(e);
        tick();
        wr_data = 39'h22;
        e = '0; e.array1[0] = 39'h22; e.written[0] = 1'b1; sb.push_back(e);
        tick();
        commit = 0;
        check_val("t3_full", commit_ready, 1'b0);
        wr_idx = 2'd2; wr_data = 39'h33;
        tick();
        wr_en = 0; commit = 1;
        tick();
        commit = 0;
        check_val("t3_drop", drop_count, 16'd1);
        repeat (3) tick();
        check_val("t3_stall_sent", sent_count, 16'd3);
        bus.ready = 1'b1;
        repeat (3) tick();
        check_val("t3_sent", sent_count, 16'd5);
        check_val("t3_sb_empty", sb.size(), 0);
        commit = 1;
        e = '0; e.array1[2] = 39'h33; e.written[2] = 1'b1; sb.push_back(e);
        tick();
        commit = 0;
        repeat (2) tick();
        check_val("t3_retry_sent", sent_count, 16'd6);

        // full FIFO with commit and pop in the same cycle
        bus.ready = 1'b0;
        wr_en = 1; wr_idx = 2'd1; wr_data = 39'h44; commit = 1;
        e = '0; e.array1[1] = 39'h44; e.written[1] = 1'b1; sb.push_back(e);
        tick();
        wr_data = 39'h55;
        e = '0; e.array1[1] = 39'h55; e.written[1] = 1'b1; sb.push_back(e);
        tick();
        wr_idx = 2'd2; wr_data = 39'h66; bus.ready = 1'b1;
        tick();
        wr_en = 0; commit = 0;
        check_val("t4_commit_ready", commit_ready, 1'b1);
        check_val("t4_drop", drop_count, 16'd2);
        tick();
        commit = 1;
        e = '0; e.array1[2] = 39'h66; e.written[2] = 1'b1; sb.push_back(e);
        tick();
        commit = 0;
        repeat (2) tick();
        check_val("t4_sent", sent_count, 16'd9);

        // index range on a 5-element shape
        wr_en5 = 1; wr_idx5 = 3'd4; wr_data5 = 39'h77;
        tick();
        wr_idx5 = 3'd6; wr_data5 = 39'h88;
        tick();
        wr_idx5 = 3'd5;
        tick();
        wr_en5 = 0; commit5 = 1;
        tick();
        commit5 = 0;
        e5 = '0; e5.array1[4] = 39'h77; e5.written[4] = 1'b1;
        check_val("t5_valid", bus5.valid, 1'b1);
        check_val("t5_data", bus5.data, e5);

        // asynchronous reset with two messages queued
        bus.ready = 1'b0;
        wr_en = 1; wr_idx = 2'd0; wr_data = 39'h99; commit = 1;
        e = '0; e.array1[0] = 39'h99; e.written[0] = 1'b1; sb.push_back(e);
        tick();
        wr_en = 0;
        sb.push_back('0);
        tick();
        commit = 0;
        check_val("t6_full", commit_ready, 1'b0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        sb.delete();
        #1;
        check_val("t6_valid", bus.valid, 1'b0);
        check_val("t6_data", bus.data, '0);
        check_val("t6_sent", sent_count, 16'd0);
        check_val("t6_drop", drop_count, 16'd0);
        check_val("t6_commit_ready", commit_ready, 1'b1);
        check_val("t6_valid5", bus5.valid, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
        bus.ready = 1'b1;
        wr_en = 1; wr_idx = 2'd2; wr_data = 39'hAB; commit = 1;
        e = '0; e.array1[2] = 39'hAB; e.written[2] = 1'b1; sb.push_back(e);
        tick();
        wr_en = 0; commit = 0;
        repeat (2) tick();
        check_val("t6_after_sent", sent_count, 16'd1);
        check_val("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
